// File: rtl/lt24_pixel_sink.sv
// LT24 (ILI9341) pixel sink: one pixel per valid/ready handshake onto the 8080 write bus.
// Ports: clock, globalRst_n, enable, pixel request (xAddr/yAddr/pixelData/pixelWrite/pixelReady),
//        busy, LT24CS_n/LT24RS/LT24Wr_n/LT24Rd_n/LT24Data panel pins.
`timescale 1ns/1ps
module lt24_pixel_sink #(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 320,
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic        clock,
    input  logic        globalRst_n,
    input  logic        enable,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        busy,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic [15:0] LT24Data
);

    localparam int PH = WR_LOW + WR_HIGH;
    localparam int CW = $clog2(PH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PH - 1);
    localparam logic [CW-1:0] CNT_RISE = CW'(WR_LOW);
    localparam logic [7:0]  X_LAST   = 8'(WIDTH - 1);
    localparam logic [8:0]  Y_LAST   = 9'(HEIGHT - 1);
    localparam logic [15:0] X_MAX    = 16'(WIDTH - 1);
    localparam logic [15:0] Y_MAX    = 16'(HEIGHT - 1);
    localparam logic [3:0]  IDX_LAST = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DATA,
        DONE
    } state_t;

    state_t        state;
    logic [3:0]    idx;
    logic [CW-1:0] cnt;
    logic [7:0]    x_q;
    logic [8:0]    y_q;
    logic [15:0]   d_q;
    logic [7:0]    x_start;
    logic [8:0]    y_start;
    logic [7:0]    exp_x;
    logic [8:0]    exp_y;
    logic          seq_valid;
    logic          enable_q;

    logic          accept;
    logic          in_range;
    logic          fast;
    logic [16:0]   next_word;

    // {RS, data} for preamble write i; parameter bytes sit on the low byte.
    function automatic logic [16:0] seq_word(
        input logic [3:0]  i,
        input logic [15:0] x,
        input logic [15:0] y
    );
        logic [16:0] w;
        w = {1'b1, 16'h0000};
        unique case (i)
            4'd0:    w = {1'b0, 16'h002A};
            4'd1:    w = {1'b1, 8'h00, x[15:8]};
            4'd2:    w = {1'b1, 8'h00, x[7:0]};
            4'd3:    w = {1'b1, 8'h00, X_MAX[15:8]};
            4'd4:    w = {1'b1, 8'h00, X_MAX[7:0]};
            4'd5:    w = {1'b0, 16'h002B};
            4'd6:    w = {1'b1, 8'h00, y[15:8]};
            4'd7:    w = {1'b1, 8'h00, y[7:0]};
            4'd8:    w = {1'b1, 8'h00, Y_MAX[15:8]};
            4'd9:    w = {1'b1, 8'h00, Y_MAX[7:0]};
            4'd10:   w = {1'b0, 16'h002C};
            default: w = {1'b1, 16'h0000};
        endcase
        return w;
    endfunction

    always_comb begin
        accept    = pixelWrite && pixelReady && (state == IDLE);
        in_range  = (xAddr <= X_LAST) && (yAddr <= Y_LAST);
        fast      = seq_valid && (xAddr == exp_x) && (yAddr == exp_y);
        next_word = seq_word(idx + 4'd1, {8'h00, x_q}, {7'h00, y_q});
    end

    assign LT24Rd_n = 1'b1;

    always_ff @(posedge clock or negedge globalRst_n) begin
        if (!globalRst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            d_q        <= '0;
            x_start    <= '0;
            y_start    <= '0;
            exp_x      <= '0;
            exp_y      <= '0;
            seq_valid  <= 1'b0;
            enable_q   <= 1'b0;
            pixelReady <= 1'b0;
            busy       <= 1'b0;
            LT24CS_n   <= 1'b1;
            LT24RS     <= 1'b1;
            LT24Wr_n   <= 1'b1;
            LT24Data   <= '0;
        end else begin
            enable_q <= enable;
            // Ready is withheld on the accept edge so a held request
            // cannot be taken twice; out-of-range pixels cost one cycle.
            pixelReady <= (state == IDLE) && enable && !accept;

            unique case (state)
                IDLE: begin
                    if (accept && in_range) begin
                        x_q      <= xAddr;
                        y_q      <= yAddr;
                        d_q      <= pixelData;
                        cnt      <= '0;
                        LT24CS_n <= 1'b0;
                        busy     <= 1'b1;
                        LT24Wr_n <= 1'b0;
                        if (fast) begin
                            state    <= DATA;
                            LT24RS   <= 1'b1;
                            LT24Data <= pixelData;
                        end else begin
                            state    <= SETUP;
                            idx      <= '0;
                            x_start  <= xAddr;
                            y_start  <= yAddr;
                            LT24RS   <= 1'b0;
                            LT24Data <= 16'h002A;
                        end
                    end
                end
                SETUP, DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (state == DATA) begin
                            state    <= DONE;
                            LT24CS_n <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            LT24Wr_n <= 1'b0;
                            if (idx == IDX_LAST) begin
                                state    <= DATA;
                                LT24RS   <= 1'b1;
                                LT24Data <= d_q;
                            end else begin
                                idx <= idx + 4'd1;
                                {LT24RS, LT24Data} <= next_word;
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (cnt + CW'(1) == CNT_RISE) begin
                            LT24Wr_n <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Track where the panel's auto-increment will land next.
                    if (x_q < X_LAST) begin
                        exp_x <= x_q + 8'd1;
                        exp_y <= y_q;
                    end else if (y_q < Y_LAST) begin
                        exp_x <= x_start;
                        exp_y <= y_q + 9'd1;
                    end else begin
                        exp_x <= x_start;
                        exp_y <= y_start;
                    end
                    seq_valid <= 1'b1;
                    state     <= IDLE;
                end
            endcase

            if (enable_q && !enable) begin
                seq_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/lt24_pixel_sink.md
Name: lt24_pixel_sink

Overview:
- Responder end of the team's pixel-write interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady).
- Accepts one pixel per handshake and drives the LT24 (ILI9341) 8080-style parallel bus: one data write for in-sequence pixels, full column/page/memory-write command preamble on address discontinuity.
- Sits between the scope pixel generators and the LT24 pins.
- Panel power-up/init is out of scope; `enable` is raised once init is done.

Parameters:
- WIDTH, 240, panel columns; x range 0..WIDTH-1
- HEIGHT, 320, panel rows; y range 0..HEIGHT-1
- WR_LOW, 2, clock cycles LT24Wr_n held low per bus write (min 1)
- WR_HIGH, 2, clock cycles LT24Wr_n held high after each write; data/RS stable (min 1)

Ports:
- clock  in  1  system clock, 50 MHz
- globalRst_n  in  1  asynchronous active-low reset
- enable  in  1  panel initialised; pixelReady is gated by it
- xAddr  in  8  pixel column
- yAddr  in  9  pixel row
- pixelData  in  16  RGB565 colour
- pixelWrite  in  1  producer request
- pixelReady  out  1  sink can accept this cycle
- busy  out  1  bus transaction in progress
- LT24CS_n  out  1  chip select, low during a transaction
- LT24RS  out  1  0 = command byte, 1 = data
- LT24Wr_n  out  1  write strobe; panel latches on rising edge
- LT24Rd_n  out  1  tied 1
- LT24Data  out  16  bus data

Behaviour:
- Reset (async, globalRst_n low):
  - Outputs: pixelReady=0, busy=0, CS_n=1, RS=1, Wr_n=1, Rd_n=1, LT24Data=0.
  - State: IDLE; seqValid=0; xStart=0, yStart=0; expected-address registers = 0.
  - Reset mid-transaction aborts immediately. The partial transfer is lost; the next pixel always re-addresses.
- Handshake:
  - Transfer occurs on a rising edge with pixelWrite && pixelReady.
  - pixelReady = registered (state==IDLE && enable). It drops the cycle after acceptance.
  - x/y/data are captured on acceptance; later input changes are ignored.
- Address decision at accept:
  - Fast path if seqValid && x==expX && y==expY: DATA state only.
  - Otherwise slow path: latch xStart=x, yStart=y, then run the preamble.
- Preamble (11 writes, in order):
  - CMD 0x2A
  - DAT {8'h0,x[15:8]}, DAT x[7:0]
  - DAT (WIDTH-1)>>8, DAT (WIDTH-1)&0xFF
  - CMD 0x2B
  - DAT y>>8, DAT y&0xFF
  - DAT (HEIGHT-1)>>8, DAT (HEIGHT-1)&0xFF
  - CMD 0x2C
  - Then DAT pixelData. Total 12 bus writes.
  - Command/parameter bytes go on LT24Data[7:0] with upper bits 0.
- Bus write cycle:
  - RS and LT24Data are set on the first cycle.
  - Wr_n is low for WR_LOW cycles, then high for WR_HIGH cycles.
  - CS_n stays low from the first cycle of the first write until the final WR_HIGH period ends.
  - busy equals !CS_n.
- FSM states: IDLE, SETUP (sequencer index 0..10 over preamble), DATA, DONE.
  - DONE is 1 cycle: CS_n=1, update expected address, return to IDLE.
- Latency and throughput:
  - Fast path: accept-to-pixelReady-high = WR_LOW+WR_HIGH+2 cycles (6 at defaults).
  - Slow path: 12*(WR_LOW+WR_HIGH)+2 cycles (50 at defaults).
- Expected-address update (mirrors the panel's auto-increment within the window):
  - If x<WIDTH-1: expX=x+1, expY=y.
  - Else if y<HEIGHT-1: expX=xStart, expY=y+1.
  - Else: expX=xStart, expY=yStart.
  - seqValid is set to 1 after every completed pixel.
- Out of range: an accepted pixel with x>=WIDTH or y>=HEIGHT is dropped. No bus activity, seqValid is unaffected, and pixelReady returns 1 cycle after acceptance.
- enable:
  - Low gates only new acceptance; an in-flight transaction completes.
  - A falling edge of enable clears seqValid.

Test Plan:
1. Reset then enable=1; write (0,0,16'hF800) → bus sequence 2A,00,00,00,EF,2B,00,00,01,3F,2C with RS=0 on commands; then data F800 with RS=1; 12 Wr_n rising edges; pixelReady high 50 cycles after accept.
2. Follow with (1,0,16'h07E0) → single data write 07E0, no commands, pixelReady back after 6 cycles.
3. Stream the full 240x320 raster from (0,0) with pixelWrite held 1 → exactly 11 command/param writes total plus 76800 data writes; the first pixel of the next frame, (0,0), needs no re-address.
4. After (5,5), write (9,5) → full preamble with x param bytes 00,09; after (239,7) from a window starting at x=10, write (10,8) → fast path.
5. Write (240,0) → no Wr_n pulse, CS_n stays 1, seqValid unchanged.
6. Assert globalRst_n low during preamble write 4 → all bus outputs idle immediately; after release, (1,0) produces the full preamble; holding enable=0 with pixelWrite=1 → pixelReady stays 0.
